// File: rtl/fc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fc_sequencer
//  Purpose  : Buffers one frame of pooled features, replays it to the fully
//             connected stage as a gap-free burst, captures the class scores
//             and resolves the winning digit with a sequential signed argmax.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_sequencer #(
    parameter int BEATS       = 25,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 9,
    parameter int TIMEOUT     = 1023
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           feat_valid,
    input  logic [15:0]                    feat_in,
    output logic                           feat_ready,
    output logic                           fc_valid,
    output logic [15:0]                    fc_pixel,
    input  logic [NUM_CLASSES*SCORE_W-1:0] fc_scores,
    input  logic                           fc_score_valid,
    output logic                           digit_valid,
    output logic [3:0]                     digit,
    output logic [SCORE_W-1:0]             max_score,
    input  logic                           digit_ready,
    input  logic                           err_clr,
    output logic                           overrun,
    output logic                           timeout
);

    // One shared counter serves as stream index, WAIT cycle count and argmax
    // class index, so it is sized for the largest of those (the timeout).
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  C_BEATS     = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0]  C_TIMEOUT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_CLS_LAST  = CNT_W'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_STREAM  = 3'd1,
        S_WAIT    = 3'd2,
        S_ARGMAX  = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        fc_valid_q, fc_valid_d;
    logic [15:0]                 fc_pixel_q, fc_pixel_d;
    logic                        digit_valid_q, digit_valid_d;
    logic [3:0]                  digit_q, digit_d;
    logic [SCORE_W-1:0]          max_score_q, max_score_d;
    logic [3:0]                  best_q, best_d;
    logic signed [SCORE_W-1:0]   bestval_q, bestval_d;
    logic                        overrun_q, overrun_d;
    logic                        timeout_q, timeout_d;

    // Data storage without reset: contents are always rewritten before use.
    logic [15:0]                 feat_buf_q [BEATS];
    logic signed [SCORE_W-1:0]   score_q    [NUM_CLASSES];
    logic                        buf_we;
    logic                        score_we;

    logic signed [SCORE_W-1:0]   w_scores [NUM_CLASSES];
    logic signed [SCORE_W-1:0]   w_cand;
    logic                        w_gt;
    logic [3:0]                  w_best_nxt;
    logic signed [SCORE_W-1:0]   w_bestval_nxt;
    logic [CNT_W-1:0]            w_cnt_inc;

    generate
        for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_unpack
            assign w_scores[g] = fc_scores[g*SCORE_W +: SCORE_W];
        end
    endgenerate

    assign feat_ready    = (state_q == S_COLLECT);
    assign w_cnt_inc     = cnt_q + 1'b1;
    assign w_cand        = score_q[cnt_q[3:0]];
    assign w_gt          = (w_cand > bestval_q);            // signed compare
    assign w_best_nxt    = w_gt ? cnt_q[3:0] : best_q;      // ties keep lower index
    assign w_bestval_nxt = w_gt ? w_cand : bestval_q;

    // Next-state and registered-output decode for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        cnt_d         = cnt_q;
        fc_valid_d    = fc_valid_q;
        fc_pixel_d    = fc_pixel_q;
        digit_valid_d = digit_valid_q;
        digit_d       = digit_q;
        max_score_d   = max_score_q;
        best_d        = best_q;
        bestval_d     = bestval_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        buf_we        = 1'b0;
        score_we      = 1'b0;

        // Clear first so that a set event in the same cycle takes priority.
        if (err_clr) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (feat_valid && (state_q != S_COLLECT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_COLLECT: begin
                if (feat_valid) begin
                    buf_we = 1'b1;
                    if (beat_cnt_q == C_BEAT_LAST) begin
                        // First burst beat goes out on the cycle after the
                        // final accept; buf[0] is already stable.
                        beat_cnt_d = '0;
                        state_d    = S_STREAM;
                        fc_valid_d = 1'b1;
                        fc_pixel_d = feat_buf_q[0];
                        cnt_d      = CNT_W'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (cnt_q == C_BEATS) begin
                    fc_valid_d = 1'b0;
                    fc_pixel_d = '0;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end else begin
                    fc_pixel_d = feat_buf_q[cnt_q[BEAT_W-1:0]];
                    cnt_d      = w_cnt_inc;
                end
            end
            S_WAIT: begin
                if (fc_score_valid) begin
                    score_we  = 1'b1;
                    best_d    = '0;
                    bestval_d = w_scores[0];
                    cnt_d     = CNT_W'(1);
                    state_d   = S_ARGMAX;
                end else if (w_cnt_inc == C_TIMEOUT) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_COLLECT;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_ARGMAX: begin
                best_d    = w_best_nxt;
                bestval_d = w_bestval_nxt;
                if (cnt_q == C_CLS_LAST) begin
                    digit_valid_d = 1'b1;
                    digit_d       = w_best_nxt;
                    max_score_d   = w_bestval_nxt;
                    cnt_d         = '0;
                    state_d       = S_OUT;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_OUT: begin
                if (digit_ready) begin
                    digit_valid_d = 1'b0;
                    state_d       = S_COLLECT;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // Control and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_COLLECT;
            beat_cnt_q    <= '0;
            cnt_q         <= '0;
            fc_valid_q    <= 1'b0;
            fc_pixel_q    <= '0;
            digit_valid_q <= 1'b0;
            digit_q       <= '0;
            max_score_q   <= '0;
            best_q        <= '0;
            bestval_q     <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            cnt_q         <= cnt_d;
            fc_valid_q    <= fc_valid_d;
            fc_pixel_q    <= fc_pixel_d;
            digit_valid_q <= digit_valid_d;
            digit_q       <= digit_d;
            max_score_q   <= max_score_d;
            best_q        <= best_d;
            bestval_q     <= bestval_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    // Feature buffer and score snapshot writes.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            feat_buf_q[beat_cnt_q] <= feat_in;
        end
        if (score_we) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_q[i] <= w_scores[i];
            end
        end
    end

    assign fc_valid    = fc_valid_q;
    assign fc_pixel    = fc_pixel_q;
    assign digit_valid = digit_valid_q;
    assign digit       = digit_q;
    assign max_score   = max_score_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_sequencer
//  Purpose  : Directed self-checking bench for fc_sequencer with a stub FC.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        feat_valid = 1'b0;
    logic [15:0] feat_in = '0;
    logic        feat_ready;
    logic        fc_valid;
    logic [15:0] fc_pixel;
    logic [89:0] fc_scores = '0;
    logic        fc_score_valid = 1'b0;
    logic        digit_valid;
    logic [3:0]  digit;
    logic [8:0]  max_score;
    logic        digit_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        overrun;
    logic        timeout;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] frame [25];
    int          sc [10];

    fc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .feat_valid     (feat_valid),
        .feat_in        (feat_in),
        .feat_ready     (feat_ready),
        .fc_valid       (fc_valid),
        .fc_pixel       (fc_pixel),
        .fc_scores      (fc_scores),
        .fc_score_valid (fc_score_valid),
        .digit_valid    (digit_valid),
        .digit          (digit),
        .max_score      (max_score),
        .digit_ready    (digit_ready),
        .err_clr        (err_clr),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives frame[lo..hi] at negedges with up to gapmax idle cycles between beats;
    // returns at the negedge after the last beat with feat_valid low.
    task automatic send_beats(input int lo, input int hi, input int gapmax);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            feat_valid = 1'b1;
            feat_in    = frame[k];
            if (k < hi && gapmax > 0) begin
                repeat ($urandom_range(0, gapmax)) begin
                    @(negedge clk);
                    feat_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        feat_valid = 1'b0;
        feat_in    = '0;
    endtask

    task automatic capture_burst(input string tag);
        int w = 0;
        while (!fc_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " burst_start_delay"}, w, 0);
        for (int i = 0; i < 25; i++) begin
            chk({tag, " burst_valid"}, fc_valid, 1);
            chk({tag, " burst_pixel"}, fc_pixel, frame[i]);
            @(negedge clk);
        end
        chk({tag, " burst_end_valid"}, fc_valid, 0);
        chk({tag, " burst_end_pixel"}, fc_pixel, 0);
    endtask

    // Stub FC: returns sc[] about 8 cycles after the burst, then measures latency.
    task automatic score_result(input string tag, input int exp_d, input int exp_m);
        int         lat;
        logic [8:0] em;
        em = 9'(exp_m);
        repeat (7) @(negedge clk);
        for (int i = 0; i < 10; i++) fc_scores[i*9 +: 9] = 9'(sc[i]);
        fc_score_valid = 1'b1;
        @(negedge clk);
        fc_score_valid = 1'b0;
        lat = 1;
        while (!digit_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 10);
        chk({tag, " digit"}, digit, exp_d);
        chk({tag, " max_score"}, max_score, em);
    endtask

    task automatic handshake(input string tag);
        digit_ready = 1'b1;
        @(negedge clk);
        digit_ready = 1'b0;
        chk({tag, " release_dv"}, digit_valid, 0);
        chk({tag, " release_ready"}, feat_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic seen;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst feat_ready", feat_ready, 1);
        chk("rst fc_valid", fc_valid, 0);
        chk("rst fc_pixel", fc_pixel, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst digit_valid", digit_valid, 0);
        chk("rst digit", digit, 0);
        chk("rst max_score", max_score, 0);
        chk("rst overrun", overrun, 0);
        chk("rst timeout", timeout, 0);

        // ---------------- all-ones frame, scores 10*i ----------------
        for (int k = 0; k < 25; k++) frame[k] = 16'hFFFF;
        for (int i = 0; i < 10; i++) sc[i] = 10 * i;
        send_beats(0, 24, 0);
        capture_burst("ones");
        score_result("ones", 9, 90);
        handshake("ones");

        // ---------------- gapped unique pattern, signed tie at top ----------------
        for (int k = 0; k < 25; k++) frame[k] = 16'(k);
        sc[0] = -5; sc[1] = -5;
        for (int i = 2; i < 10; i++) sc[i] = -200;
        send_beats(0, 24, 3);
        capture_burst("gap");
        score_result("gap", 0, -5);
        handshake("gap");

        // ---------------- tie at index 1, backpressure and overrun ----------------
        for (int k = 0; k < 25; k++) frame[k] = 16'h5A5A ^ 16'(k * 257);
        sc = '{0, 7, 7, 3, 0, 0, 0, 0, 0, 0};
        send_beats(0, 24, 0);
        capture_burst("bp");
        score_result("bp", 1, 7);
        for (int i = 0; i < 20; i++) begin
            chk("bp hold_digit", digit, 1);
            chk("bp hold_dv", digit_valid, 1);
            if (i == 0) chk("bp hold_ready", feat_ready, 0);
            if (i == 6) chk("bp overrun_set", overrun, 1);
            if (i == 11) chk("bp set_wins_over_clr", overrun, 1);
            feat_valid = (i == 5) || (i == 10);
            feat_in    = 16'hDEAD;
            err_clr    = (i == 10);
            @(negedge clk);
        end
        feat_valid = 1'b0;
        err_clr    = 1'b0;
        chk("bp hold_end_overrun", overrun, 1);
        handshake("bp");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("bp overrun_cleared", overrun, 0);

        // ---------------- timeout ----------------
        for (int k = 0; k < 25; k++) frame[k] = 16'hA5A5 ^ 16'(k);
        send_beats(0, 24, 0);
        capture_burst("to");
        t = 0;
        while (!timeout && t < 1100) begin
            @(negedge clk);
            t++;
            if (digit_valid) chk("to spurious_dv", digit_valid, 0);
        end
        chk("to cycles", t, 1023);
        chk("to feat_ready", feat_ready, 1);
        chk("to digit_valid", digit_valid, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to cleared", timeout, 0);
        sc = '{3, -1, 50, 50, 12, -100, 49, 0, 8, 50};
        for (int k = 0; k < 25; k++) frame[k] = 16'h0F0F + 16'(k);
        send_beats(0, 24, 0);
        capture_burst("after_to");
        score_result("after_to", 2, 50);
        handshake("after_to");

        // ---------------- reset mid-STREAM ----------------
        for (int k = 0; k < 25; k++) frame[k] = 16'h8000 | 16'(k);
        send_beats(0, 24, 0);
        chk("rs burst_began", fc_valid, 1);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rs async_fc_valid", fc_valid, 0);
        chk("rs async_fc_pixel", fc_pixel, 0);
        chk("rs async_ready", feat_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) frame[k] = 16'hC000 | 16'(k * 3);
        send_beats(0, 23, 1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen = seen | fc_valid;
            @(negedge clk);
        end
        chk("rs no_burst_on_partial", seen, 0);
        send_beats(24, 24, 0);
        capture_burst("rs");
        sc = '{-1, -2, -3, -4, -5, -6, 100, -8, -9, -10};
        score_result("rs", 6, 100);
        handshake("rs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
